// File: rtl/ram_arb_pkg.sv
// Shared helpers for the RAM read-port arbiter family.
// Holds the latency and index-width rules so the top and any
// write-side sequencers size their logic the same way.
package ram_arb_pkg;

  // Read latency of the attached RAM: one cycle for the plain array
  // read, two when the optional output register is enabled.
  function automatic int rd_latency(input bit reg_rd_data);
    return reg_rd_data ? 2 : 1;
  endfunction

  // Width of an encoded requester index, never less than one bit so a
  // two-requester arbiter still has a real pointer register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// The search begins one past lastGrant and wraps with an explicit
// compare against NUM_REQ-1, so NUM_REQ need not be a power of two.
// The pointer register is owned by whoever instantiates this block.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] foundIdx;
  logic             found;

  // Walk every requester once starting after the last winner; the first
  // active request met wins, which gives each requester a fair turn.
  always_comb begin
    cand     = last_grant_i;
    foundIdx = '0;
    found    = 1'b0;
    grant_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand >= IDX_W'(NUM_REQ - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IDX_W'(1);
      end
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        foundIdx = cand;
      end
    end
    if (found) begin
      grant_o[foundIdx] = 1'b1;
    end
    grant_idx_o = foundIdx;
    grant_any_o = found;
  end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Shares the single read port of a simple-dual-port RAM between
// NUM_REQ requesters. Grants are round-robin and combinational; each
// accepted read is tagged with its requester index and carried down a
// LAT-deep valid/id pipeline so the returning word is routed back to
// whoever asked for it. Responses are never back-pressured.
module ram_rd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter bit REG_RD_DATA = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  localparam int LAT   = rd_latency(REG_RD_DATA);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grantIdx;
  logic                  grantAny;

  logic [IDX_W-1:0]      lastGrant_q;
  logic [IDX_W-1:0]      lastGrant_d;
  logic [LAT-1:0]        pipeValid_q;
  logic [LAT-1:0]        pipeValid_d;
  logic [IDX_W-1:0]      pipeId_q [LAT];
  logic [IDX_W-1:0]      pipeId_d [LAT];

  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [NUM_REQ-1:0]    respValid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uArb (
    .req_i        (req_valid),
    .last_grant_i (lastGrant_q),
    .grant_o      (grant),
    .grant_idx_o  (grantIdx),
    .grant_any_o  (grantAny)
  );

  // A grant is only issued to a valid requester, so a grant is an accept.
  assign req_ready = grant;

  // Pointer advances to the winner on every accept and holds otherwise.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grantAny) begin
      lastGrant_d = grantIdx;
    end
  end

  // Steer the winner's address to the RAM; zero when idle keeps it tidy.
  always_comb begin
    rdAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rdAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign ram_rd_addr = rdAddr;

  // With a registered RAM output the second stage only loads while rd_en
  // is high, so keep it enabled while a read sits in the first stage.
  assign ram_rd_en = grantAny | (REG_RD_DATA & pipeValid_q[0]);

  // Stage 0 captures this cycle's accept; later stages shift one per cycle.
  always_comb begin
    pipeValid_d[0] = grantAny;
    pipeId_d[0]    = grantIdx;
    for (int s = 1; s < LAT; s++) begin
      pipeValid_d[s] = pipeValid_q[s-1];
      pipeId_d[s]    = pipeId_q[s-1];
    end
  end

  // State registers; reset points at the last index so requester 0 wins first
  // and drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= IDX_W'(NUM_REQ - 1);
      pipeValid_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        pipeId_q[s] <= '0;
      end
    end else begin
      lastGrant_q <= lastGrant_d;
      pipeValid_q <= pipeValid_d;
      for (int s = 0; s < LAT; s++) begin
        pipeId_q[s] <= pipeId_d[s];
      end
    end
  end

  // Decode the last stage into a one-hot response strobe.
  always_comb begin
    respValid = '0;
    if (pipeValid_q[LAT-1]) begin
      respValid[pipeId_q[LAT-1]] = 1'b1;
    end
  end

  assign resp_valid = respValid;

  // The RAM word lines up with the last stage, so it passes straight out.
  assign resp_data = ram_rd_data;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Scoreboard bench for ram_rd_arbiter. Two configurations run side by side:
// NUM_REQ=2 with an unregistered RAM and NUM_REQ=3 with a registered RAM.
// Each has its own RAM model, driver with a round-robin reference model,
// and a monitor that pops expected responses as they come back.
module tb_ram_rd_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Free-running clock and cycle counter shared by both configurations.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar c = 0; c < 2; c++) begin : gCfg
    localparam int NR  = (c == 0) ? 2 : 3;
    localparam bit RR  = (c == 1);
    localparam int LAT = RR ? 2 : 1;

    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      resp_valid;
    logic [DW-1:0]      resp_data;
    logic               ram_rd_en;
    logic [AW-1:0]      ram_rd_addr;
    logic [DW-1:0]      ram_rd_data;

    logic [DW-1:0]      mem [64];
    logic [DW-1:0]      ramS1;
    logic [DW-1:0]      ramS2;
    exp_t               q[$];
    int                 last;
    bit                 done;

    ram_rd_arbiter #(
      .NUM_REQ     (NR),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .REG_RD_DATA (RR)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
    );

    // RAM contents: distinct filler plus the values the directed cases name.
    initial begin
      for (int i = 0; i < 64; i++) mem[i] = DW'(i * 37 + 11 + c * 5);
      mem[1] = 8'h11;
      mem[2] = 8'h22;
      mem[3] = 8'h33;
      mem[5] = 8'hA5;
    end

    // RAM read port: array read, optional output register gated by rd_en.
    always @(posedge clk) begin
      if (ram_rd_en) begin
        ramS1 <= mem[ram_rd_addr];
        ramS2 <= ramS1;
      end
    end

    assign ram_rd_data = RR ? ramS2 : ramS1;

    // One cycle of stimulus: drive, check the grant against round-robin
    // rules, and record the expected response if a request was accepted.
    task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                 output int g);
      logic [NR-1:0] expReady;
      int j;
      exp_t e;
      @(negedge clk);
      req_valid = v;
      req_addr  = a;
      #1;
      expReady = '0;
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        j = (last + k) % NR;
        if (g < 0 && v[j]) g = j;
      end
      if (g >= 0) expReady[g] = 1'b1;
      checks++;
      if (req_ready !== expReady)
        begin
          errors++;
          $display("[TB] FAIL cfg%0d req_ready cyc %0d: got %b want %b", c, cyc, req_ready, expReady);
        end
      if (!rst_n) g = -1;
      if (g >= 0) begin
        e.id   = g;
        e.data = mem[a[g*AW +: AW]];
        e.cyc  = cyc + LAT;
        q.push_back(e);
        last = g;
      end
    endtask

    // Hold reset for n cycles, discarding everything expected in flight.
    task automatic applyReset(input int n);
      int g;
      rst_n = 1'b0;
      q.delete();
      last = NR - 1;
      repeat (n) applyStimulus('0, '0, g);
      rst_n = 1'b1;
    endtask

    // Monitor: every cycle the strobe must match the scoreboard head exactly.
    task automatic checkOutput();
      logic [NR-1:0] expVec;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL cfg%0d missing resp id %0d due cyc %0d: got none want one", c, q[0].id, q[0].cyc);
        void'(q.pop_front());
      end
      expVec = '0;
      if (q.size() > 0 && q[0].cyc == cyc) expVec[q[0].id] = 1'b1;
      checks++;
      if (resp_valid !== expVec) begin
        errors++;
        $display("[TB] FAIL cfg%0d resp_valid cyc %0d: got %b want %b", c, cyc, resp_valid, expVec);
      end
      if (expVec != '0) begin
        checks++;
        if (resp_data !== q[0].data) begin
          errors++;
          $display("[TB] FAIL cfg%0d resp_data cyc %0d: got %h want %h", c, cyc, resp_data, q[0].data);
        end
        void'(q.pop_front());
      end
    endtask

    initial begin
      forever begin
        @(negedge clk);
        #2;
        checkOutput();
      end
    end

    // Directed scenarios followed by a randomised mix.
    initial begin
      int g;
      logic [NR-1:0] v;
      logic [NR*AW-1:0] a;
      done      = 1'b0;
      last      = NR - 1;
      req_valid = '0;
      req_addr  = '0;
      applyReset(3);

      // Lone request from requester 0 right after reset.
      a = '0;
      a[0 +: AW] = AW'(5);
      applyStimulus(NR'(1), a, g);
      repeat (3) applyStimulus('0, a, g);

      // Everyone streaming from reset: grants rotate with no gaps.
      applyReset(2);
      for (int i = 0; i < NR; i++) a[i*AW +: AW] = AW'(i + 1);
      repeat (4 * NR) applyStimulus('1, a, g);
      repeat (2) applyStimulus('0, a, g);

      // Requester 0 streams alone, then the others join.
      repeat (4) applyStimulus(NR'(1), a, g);
      repeat (3) applyStimulus('1, a, g);

      // One request from each requester on consecutive cycles.
      for (int i = 0; i < NR; i++) applyStimulus(NR'(1) << i, a, g);
      repeat (LAT + 2) applyStimulus('0, a, g);

      // Reset a cycle after an accept: nothing may come back afterwards.
      applyStimulus(NR'(2), a, g);
      applyStimulus('0, a, g);
      applyReset(2);
      repeat (LAT + 3) applyStimulus('0, a, g);
      applyStimulus('1, a, g);

      // Random traffic; a waiting requester keeps its address or gives up.
      v = '0;
      g = -1;
      for (int n = 0; n < 400; n++) begin
        for (int i = 0; i < NR; i++) begin
          if (v[i] && g != i) begin
            if ($urandom_range(7) == 0) v[i] = 1'b0;
          end else begin
            v[i] = 1'($urandom_range(1));
            a[i*AW +: AW] = AW'($urandom_range(63));
          end
        end
        applyStimulus(v, a, g);
      end
      repeat (LAT + 3) applyStimulus('0, a, g);

      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("[TB] FAIL cfg%0d drain: got %0d outstanding want 0", c, q.size());
      end
      done = 1'b1;
    end
  end

  // Wait for both configurations within a cycle budget, then summarise.
  initial begin
    for (int k = 0; k < 60000; k++) begin
      @(posedge clk);
      if (gCfg[0].done && gCfg[1].done) break;
    end
    checks++;
    if (!(gCfg[0].done && gCfg[1].done)) begin
      errors++;
      $display("[TB] FAIL timeout: got unfinished want finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
